// File: rtl/act_quant_pipe_if.sv
// act_quant_pipe_if: beat-level handshake bundle for act_quant_pipe.
// Both sides use valid/ready handshakes. A beat moves on a rising edge where
// valid && ready. The producer holds valid and its payload steady until that
// edge. The consumer may raise or lower ready at any time.
// The slave modport is the pipeline's view. The master modport is the
// environment's view: it drives the input side and consumes the output side.
interface act_quant_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int SHIFT_W   = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [CHANNELS*IN_WIDTH-1:0]    in_data;
    logic [1:0]                      mode;
    logic [SHIFT_W-1:0]              shift;
    logic                            out_valid;
    logic                            out_ready;
    logic [CHANNELS*OUT_WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, mode, shift, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, shift, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/act_quant_pipe.sv
// act_quant_pipe: two-stage multi-lane activation and requantisation.
// Stage 1 applies round-half-up arithmetic shift and then the activation
// selected by mode. Stage 2 clamps each lane to signed OUT_WIDTH.
// All intermediate arithmetic is IN_WIDTH+1 bits wide, so the rounding add
// cannot overflow before the clamp.
// Optional feature macro: ACT_SAT_CNT_EN builds the any_clamped flag and the
// 16-bit saturation-event counter. Without it, sat_count is tied to zero.
module act_quant_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int SHIFT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    act_quant_pipe_if.slave      bus,
    input  logic                 clr_sat,
    output logic [15:0]          sat_count
);
    localparam int W1 = IN_WIDTH + 1;
    localparam logic signed [W1-1:0] MAX_V = (W1'(1) << (OUT_WIDTH - 1)) - W1'(1);
    localparam logic signed [W1-1:0] MIN_V = -MAX_V - W1'(1);

    logic                          stall;
    logic [W1-1:0]                 rnd;
    logic [CHANNELS*W1-1:0]        act_bus;
    logic [CHANNELS*W1-1:0]        s1_data;
    logic                          s1_valid;
    logic [CHANNELS*OUT_WIDTH-1:0] clamp_bus;
    logic [CHANNELS-1:0]           clamp_flags;

    // One global stall freezes both stages. There is no skid buffer, so
    // in_ready follows out_ready combinationally.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    // Rounding bias is half an output LSB, i.e. 2^(shift-1), or 0 when shift is 0.
    always_comb begin
        rnd = '0;
        if (bus.shift != '0) begin
            rnd = W1'(1) << (bus.shift - SHIFT_W'(1));
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [W1-1:0] x;
        logic signed [W1-1:0] rounded;
        logic signed [W1-1:0] act;
        logic signed [W1-1:0] s1_a;
        logic                 hi;
        logic                 lo;

        assign x       = $signed({bus.in_data[k*IN_WIDTH+IN_WIDTH-1],
                                  bus.in_data[k*IN_WIDTH +: IN_WIDTH]});
        assign rounded = (x + $signed(rnd)) >>> bus.shift;

        // Activation selection. The reserved mode falls back to plain saturate.
        always_comb begin
            act = rounded;
            case (bus.mode)
                2'b01:   if (rounded[W1-1]) act = '0;
                2'b10:   if (rounded[W1-1]) act = rounded >>> 3;
                default: act = rounded;
            endcase
        end

        assign act_bus[k*W1 +: W1] = act;

        // Clamp the registered activation to the signed output range.
        assign s1_a = $signed(s1_data[k*W1 +: W1]);
        assign hi   = s1_a > MAX_V;
        assign lo   = s1_a < MIN_V;
        assign clamp_bus[k*OUT_WIDTH +: OUT_WIDTH] =
            hi ? MAX_V[OUT_WIDTH-1:0] :
            lo ? MIN_V[OUT_WIDTH-1:0] :
                 s1_a[OUT_WIDTH-1:0];
        assign clamp_flags[k] = hi | lo;
    end

    // Stage 1: capture rounded and activated lanes with their valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (!stall) begin
            s1_valid <= bus.in_valid;
            s1_data  <= act_bus;
        end
    end

    // Stage 2: clamped lanes become the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (!stall) begin
            bus.out_valid <= s1_valid;
            bus.out_data  <= clamp_bus;
        end
    end

`ifdef ACT_SAT_CNT_EN
    logic any_clamped;

    // any_clamped travels with the stage 2 beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_clamped <= 1'b0;
        end else if (!stall) begin
            any_clamped <= |clamp_flags;
        end
    end

    // Count transfers of clamped beats. The count saturates, and a clear wins
    // over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_sat) begin
            sat_count <= '0;
        end else if (bus.out_valid && bus.out_ready && any_clamped &&
                     (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^{clr_sat, clamp_flags};
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_act_quant_pipe.sv
// tb_act_quant_pipe: directed test of act_quant_pipe with hand-computed vectors.
// It covers the three activation modes, rounding at the shift extremes,
// backpressure, and asynchronous reset. When ACT_SAT_CNT_EN is defined, it
// also covers saturation and clearing of the event counter.
module tb_act_quant_pipe;
    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 8;
    localparam int CHANNELS  = 4;
    localparam int SHIFT_W   = 4;
`ifdef ACT_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clr_sat;
    logic [15:0] sat_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sat = 0;
    logic [63:0] exp_q[$];

    act_quant_pipe_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                        .CHANNELS(CHANNELS), .SHIFT_W(SHIFT_W)) bus ();

    act_quant_pipe #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                     .CHANNELS(CHANNELS), .SHIFT_W(SHIFT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_sat   (clr_sat),
        .sat_count (sat_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk_in(int a, int b, int c, int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] pk_out(int a, int b, int c, int d);
        return {32'd0, 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] bp_in(int i);
        return pk_in(i + 1, -(i + 2), 10 * i + 7, 100 - i);
    endfunction

    function automatic logic [63:0] bp_out(int i);
        return pk_out(i + 1, -(i + 2), 10 * i + 7, 100 - i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_sat();
        if (CNT_EN && exp_sat < 65535) exp_sat++;
    endtask

    // Single isolated beat: checks the two-cycle latency, the data and the counter.
    task automatic send_beat(input string tag, input logic [1:0] m, input logic [3:0] s,
                             input logic [63:0] din, input logic [63:0] dexp,
                             input bit clamped);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.mode      = m;
        bus.shift     = s;
        #1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.mode     = 2'b00;
        bus.shift    = 4'd0;
        bus.in_data  = '0;
        chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"}, 64'(bus.out_data), dexp);
        step();
        if (clamped) bump_sat();
        chk({tag, "_sat"}, 64'(sat_count), 64'(exp_sat));
        chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int got;
        int held;
        bit seen;
        bit acc;
        bit ovt;
        logic [63:0] hold_val;

        rst_n         = 1'b0;
        clr_sat       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 2'b00;
        bus.shift     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_sat", 64'(sat_count), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
        #1;
        chk("empty_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();

        // Directed activation and rounding vectors
        send_beat("sat_mode", 2'b00, 4'd0, pk_in(300, -300, 5, -5), pk_out(127, -128, 5, -5), 1'b1);
        send_beat("relu", 2'b01, 4'd2, pk_in(10, -10, 511, 6), pk_out(3, 0, 127, 2), 1'b1);
        send_beat("leaky", 2'b10, 4'd0, pk_in(-64, -1, 100, -2000), pk_out(-8, -1, 100, -128), 1'b1);
        send_beat("leaky_floor", 2'b10, 4'd0, pk_in(-7, -9, 127, -1024), pk_out(-1, -2, 127, -128), 1'b0);
        send_beat("reserved_sh1", 2'b11, 4'd1, pk_in(3, -3, -255, 254), pk_out(2, -1, -127, 127), 1'b0);
        send_beat("shift15", 2'b00, 4'd15, pk_in(32767, -32768, 16384, -16385), pk_out(1, -1, 1, -1), 1'b0);

        // Backpressure: five back-to-back beats, and out_ready held low for
        // six cycles once the first output appears.
        sent = 0;
        got  = 0;
        held = 0;
        seen = 1'b0;
        hold_val = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            bus.mode  = 2'b00;
            bus.shift = 4'd0;
            if (sent < 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp_in(sent);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            if (bus.out_valid && !seen) begin
                seen     = 1'b1;
                hold_val = 64'(bus.out_data);
            end
            bus.out_ready = !(seen && held < 6);
            #1;
            if (!bus.out_ready) begin
                held++;
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                chk("bp_hold", 64'(bus.out_data), hold_val);
            end
            acc = bus.in_valid && bus.in_ready;
            ovt = bus.out_valid && bus.out_ready;
            if (ovt) begin
                if (exp_q.size() == 0) begin
                    chk("bp_extra", 64'(bus.out_data), 64'hDEAD);
                end else begin
                    chk("bp_order", 64'(bus.out_data), exp_q.pop_front());
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(bp_out(sent));
                sent++;
            end
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_got", 64'(got), 64'd5);
        chk("bp_held", 64'(held), 64'd6);
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) step();
        chk("bp_no_dup", 64'(bus.out_valid), 64'd0);
        chk("bp_sat", 64'(sat_count), 64'(exp_sat));

        // Asynchronous reset with both stages full
        bus.in_valid = 1'b1;
        bus.in_data  = pk_in(300, -300, 1000, -1000);
        step();
        step();
        bus.in_valid = 1'b0;
        chk("mid_full", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_out_data", 64'(bus.out_data), 64'd0);
        chk("async_sat", 64'(sat_count), 64'd0);
        exp_sat = 0;
        step();
        rst_n = 1'b1;
        step();
        send_beat("post_rst", 2'b01, 4'd3, pk_in(-100, 100, 20, 2000), pk_out(0, 13, 3, 127), 1'b1);

`ifdef ACT_SAT_CNT_EN
        // Saturating counter: stream enough clamped beats to pass 0xFFFF.
        bus.out_ready = 1'b1;
        bus.mode      = 2'b00;
        bus.shift     = 4'd0;
        bus.in_data   = pk_in(500, 0, 0, 0);
        bus.in_valid  = 1'b1;
        repeat (65537) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        exp_sat = 65535;
        chk("sat_ceiling", 64'(sat_count), 64'hFFFF);
        send_beat("sat_hold", 2'b00, 4'd0, pk_in(-500, 0, 0, 0), pk_out(-128, 0, 0, 0), 1'b1);

        // A clear in the same cycle as a clamped transfer wins.
        bus.in_valid = 1'b1;
        bus.in_data  = pk_in(0, 400, 0, 0);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("clr_valid", 64'(bus.out_valid), 64'd1);
        clr_sat = 1'b1;
        step();
        clr_sat = 1'b0;
        exp_sat = 0;
        chk("clr_priority", 64'(sat_count), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
